rgb_to_tmds: RTL

RGB_TO_TMDS -- requirements
Module: rgb_to_tmds

---
 rtl/rgb_to_tmds.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rgb_to_tmds.sv
// Three-channel DVI TMDS encoder: two-stage pipeline (transition minimisation,
// then DC balancing) with an optional extra output register stage.
module rgb_to_tmds #(
    parameter int unsigned PIPE_EXTRA = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic [29:0] data_out,
    output logic        de_out
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]}
             + {3'b000, v[4]} + {3'b000, v[5]} + {3'b000, v[6]} + {3'b000, v[7]};
    endfunction

    // Bit i = XOR of v[0..i]; the XNOR chain is the same with odd bits inverted.
    function automatic logic [7:0] prefix_xor(input logic [7:0] v);
        logic [7:0] p;
        p = v;
        p = p ^ (p << 1);
        p = p ^ (p << 2);
        p = p ^ (p << 4);
        return p;
    endfunction

    logic [7:0] w_d   [3];
    logic [1:0] w_ctl [3];
    logic [9:0] w_s2_word [3];
    logic [9:0] w_out [3];
    logic       w_de_out;
    logic       r_de1;
    logic       r_de2;

    assign w_d[0]   = blue;
    assign w_d[1]   = green;
    assign w_d[2]   = red;
    assign w_ctl[0] = {vsync, hsync};
    assign w_ctl[1] = 2'b00;
    assign w_ctl[2] = 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_de1 <= 1'b0;
            r_de2 <= 1'b0;
        end else begin
            r_de1 <= de;
            r_de2 <= r_de1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_ch
            logic [3:0]        w_n1;
            logic              w_use_xnor;
            logic [7:0]        w_px;
            logic [8:0]        w_qm;
            logic [8:0]        r_qm;
            logic [3:0]        r_n1;
            logic [3:0]        r_n0;
            logic [1:0]        r_ctl;
            logic signed [5:0] w_diff;
            logic [9:0]        w_word;
            logic signed [5:0] w_cnt;
            logic [9:0]        r_word;
            logic signed [5:0] r_cnt;

            assign w_n1       = ones8(w_d[g]);
            assign w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_d[g][0]);
            assign w_px       = prefix_xor(w_d[g]);
            assign w_qm       = w_use_xnor ? {1'b0, w_px ^ 8'hAA} : {1'b1, w_px};

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_qm  <= '0;
                    r_n1  <= '0;
                    r_n0  <= '0;
                    r_ctl <= '0;
                end else begin
                    r_qm  <= w_qm;
                    r_n1  <= ones8(w_qm[7:0]);
                    r_n0  <= 4'd8 - ones8(w_qm[7:0]);
                    r_ctl <= w_ctl[g];
                end
            end

            assign w_diff = $signed({2'b00, r_n1}) - $signed({2'b00, r_n0});

            always_comb begin
                w_word = TOKEN_00;
                w_cnt  = '0;
                if (r_de1) begin
                    if ((r_cnt == 6'sd0) || (r_n1 == r_n0)) begin
                        w_word = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                        w_cnt  = r_cnt + (r_qm[8] ? w_diff : -w_diff);
                    end else if (((r_cnt > 6'sd0) && (r_n1 > r_n0)) ||
                                 ((r_cnt < 6'sd0) && (r_n0 > r_n1))) begin
                        w_word = {1'b1, r_qm[8], ~r_qm[7:0]};
                        w_cnt  = r_cnt + $signed({4'b0000, r_qm[8], 1'b0}) - w_diff;
                    end else begin
                        w_word = {1'b0, r_qm[8], r_qm[7:0]};
                        w_cnt  = r_cnt - (r_qm[8] ? 6'sd0 : 6'sd2) + w_diff;
                    end
                end else begin
                    unique case (r_ctl)
                        2'b00:   w_word = TOKEN_00;
                        2'b01:   w_word = TOKEN_01;
                        2'b10:   w_word = TOKEN_10;
                        default: w_word = TOKEN_11;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_word <= TOKEN_00;
                    r_cnt  <= '0;
                end else begin
                    r_word <= w_word;
                    r_cnt  <= w_cnt;
                end
            end

            assign w_s2_word[g] = r_word;
        end
    endgenerate

    generate
        if (PIPE_EXTRA != 0) begin : g_extra
            logic [9:0] r_xw0;
            logic [9:0] r_xw1;
            logic [9:0] r_xw2;
            logic       r_xde;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_xw0 <= TOKEN_00;
                    r_xw1 <= TOKEN_00;
                    r_xw2 <= TOKEN_00;
                    r_xde <= 1'b0;
                end else begin
                    r_xw0 <= w_s2_word[0];
                    r_xw1 <= w_s2_word[1];
                    r_xw2 <= w_s2_word[2];
                    r_xde <= r_de2;
                end
            end

            assign w_out[0] = r_xw0;
            assign w_out[1] = r_xw1;
            assign w_out[2] = r_xw2;
            assign w_de_out = r_xde;
        end else begin : g_direct
            assign w_out[0] = w_s2_word[0];
            assign w_out[1] = w_s2_word[1];
            assign w_out[2] = w_s2_word[2];
            assign w_de_out = r_de2;
        end
    endgenerate

    assign tmds_ch0 = w_out[0];
    assign tmds_ch1 = w_out[1];
    assign tmds_ch2 = w_out[2];
    assign de_out   = w_de_out;

    genvar b;
    generate
        for (b = 0; b < 10; b++) begin : g_ilv
            assign data_out[3*b +: 3] = {w_out[2][b], w_out[1][b], w_out[0][b]};
        end
    endgenerate

endmodule
